cla_sum_pipe: RTL

//  Two-stage pipelined carry-lookahead sum stage for the ALU adder. Consumes the per-bit generate
//  (g = a&b) and OR-propagate (p = a|b) vectors from the upstream gp stage, plus carry-in.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/cla_block_lookahead.sv | 23 ++
 rtl/cla_sum_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU adder types and block lookahead helper.
// Default sizing for the carry-lookahead sum pipeline.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLK   = 8;
  localparam int NBLK      = DEF_WIDTH / DEF_BLK;

  typedef logic [DEF_WIDTH-1:0] word_t;
  typedef logic [DEF_BLK-1:0]   blk_t;
  typedef logic [NBLK-1:0]      nblk_t;

  // Group {generate, propagate} of one block, OR-propagate form.
  function automatic logic [1:0] blk_gp(
    input blk_t g,
    input blk_t p
  );
    logic bg;
    logic bp;
    bg = 1'b0;
    bp = 1'b1;
    for (int i = 0; i < DEF_BLK; i++) begin
      bg = g[i] | (p[i] & bg);
      bp = bp & p[i];
    end
    return {bg, bp};
  endfunction

endpackage

// File: rtl/cla_block_lookahead.sv
// Intra-block carries of one lookahead block from its carry-in.
// c[i] is the carry into bit i; c[0] equals ci.
module cla_block_lookahead
  import alu_pkg::*;
#(
  parameter int BLK = DEF_BLK
) (
  input  logic [BLK-1:0] g,
  input  logic [BLK-1:0] p,
  input  logic           ci,
  output logic [BLK-1:0] c
);

  // Each carry is the group G/P of its bit prefix; upper bits are
  // masked to transparent (g=0, p=1) so one helper covers all widths.
  for (genvar i = 0; i < BLK; i++) begin : g_c
    localparam logic [BLK-1:0] M = (BLK'(1) << i) - BLK'(1);
    logic [1:0] gp;
    assign gp   = blk_gp(g & M, p | ~M);
    assign c[i] = gp[1] | (gp[0] & ci);
  end

endmodule

// File: rtl/cla_sum_pipe.sv
// Two-stage carry-lookahead sum stage with valid/ready handshake.
// Define CLA_SUM_ZERO_FLAG_EN to add the registered zero output.
module cla_sum_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef CLA_SUM_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NB = WIDTH / BLK;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic             s1_cin;
  logic [NB-1:0]    s1_bg;
  logic [NB-1:0]    s1_bp;

  logic             s2_ready;
  logic             in_fire;
  logic             s1_adv;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_ready;
  assign in_fire  = in_valid & in_ready;
  assign s1_adv   = s1_valid & s2_ready;

  logic [NB-1:0] nbg;
  logic [NB-1:0] nbp;

  for (genvar k = 0; k < NB; k++) begin : g_s1
    assign {nbg[k], nbp[k]} =
      blk_gp(g[k*BLK +: BLK], p[k*BLK +: BLK]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_cin   <= 1'b0;
      s1_bg    <= '0;
      s1_bp    <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_g     <= g;
        s1_p     <= p;
        s1_cin   <= cin;
        s1_bg    <= nbg;
        s1_bp    <= nbp;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Block carries: prefix group terms are cin-independent,
  // so cin reaches every block through one AND-OR level.
  logic [NB:0] pre_g;
  logic [NB:0] pre_p;
  logic [NB:0] bc;

  always_comb begin
    pre_g    = '0;
    pre_p    = '1;
    for (int k = 0; k < NB; k++) begin
      pre_g[k+1] = s1_bg[k] | (s1_bp[k] & pre_g[k]);
      pre_p[k+1] = pre_p[k] & s1_bp[k];
    end
  end

  assign bc = pre_g | (pre_p & {(NB+1){s1_cin}});

  logic [WIDTH-1:0] carry;

  for (genvar k = 0; k < NB; k++) begin : g_s2
    cla_block_lookahead #(.BLK(BLK)) u_blk (
      .g  (s1_g[k*BLK +: BLK]),
      .p  (s1_p[k*BLK +: BLK]),
      .ci (bc[k]),
      .c  (carry[k*BLK +: BLK])
    );
  end

  logic [WIDTH-1:0] nsum;
  logic             novf;

  assign nsum = (s1_p & ~s1_g) ^ carry;
  assign novf = carry[WIDTH-1] ^ bc[NB];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
`ifdef CLA_SUM_ZERO_FLAG_EN
      zero      <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        sum       <= nsum;
        cout      <= bc[NB];
        ovf       <= novf;
`ifdef CLA_SUM_ZERO_FLAG_EN
        zero      <= ~|nsum;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
